// File: rtl/csa_addsub_pipe.sv
// Pipelined carry-select adder/subtractor: WIDTH/SEG segments spread evenly
// over STAGES register stages, with subtract, carry-in, flags and a sideband tag.
module csa_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int SEG    = 4,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             use_cin,
    input  logic             cin,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic [TAG_W-1:0] tag_out
);
    localparam int G    = WIDTH / (SEG * STAGES);
    localparam int LAST = STAGES - 1;

    // Per-stage registers: operands, low result bits produced so far, carry, tag, valid.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic [TAG_W-1:0] t_q [STAGES];
    logic             ovf_q, zero_q;

    logic [WIDTH-1:0] nx_a [STAGES];
    logic [WIDTH-1:0] nx_b [STAGES];
    logic [WIDTH-1:0] nx_s [STAGES];
    logic             nx_c [STAGES];
    logic             nx_v [STAGES];
    logic [TAG_W-1:0] nx_t [STAGES];
    logic             nx_ovf, nx_zero;

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             advance;

    assign b_eff = sub ? ~b : b;
    assign c0    = use_cin ? cin : sub;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // The whole pipe moves as one; in_ready never looks at in_valid.
    assign advance  = !v_q[LAST] || out_ready;
    assign in_ready = advance;

    always_comb begin
        logic [WIDTH-1:0] ca, cb, cs;
        logic             cc;
        logic [SEG:0]     s0, s1;
        int               p, lo;
        nx_ovf  = 1'b0;
        nx_zero = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            p  = (k + STAGES - 1) % STAGES;
            ca = (k == 0) ? a      : a_q[p];
            cb = (k == 0) ? b_eff  : b_q[p];
            cs = (k == 0) ? '0     : s_q[p];
            cc = (k == 0) ? c0     : c_q[p];
            for (int g = 0; g < G; g++) begin
                lo = (k * G + g) * SEG;
                s0 = {1'b0, ca[lo +: SEG]} + {1'b0, cb[lo +: SEG]};
                s1 = {1'b0, ca[lo +: SEG]} + {1'b0, cb[lo +: SEG]} + (SEG+1)'(1);
                cs[lo +: SEG] = cc ? s1[SEG-1:0] : s0[SEG-1:0];
                cc = cc ? s1[SEG] : s0[SEG];
            end
            nx_a[k] = ca;
            nx_b[k] = cb;
            nx_s[k] = cs;
            nx_c[k] = cc;
            nx_v[k] = (k == 0) ? in_valid : v_q[p];
            nx_t[k] = (k == 0) ? tag_in   : t_q[p];
            if (k == LAST) begin
                nx_ovf  = (ca[WIDTH-1] == cb[WIDTH-1]) && (cs[WIDTH-1] != ca[WIDTH-1]);
                nx_zero = (cs == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
                t_q[k] <= '0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= nx_a[k];
                b_q[k] <= nx_b[k];
                s_q[k] <= nx_s[k];
                c_q[k] <= nx_c[k];
                v_q[k] <= nx_v[k];
                t_q[k] <= nx_t[k];
            end
            ovf_q  <= nx_ovf;
            zero_q <= nx_zero;
        end
    end

    assign out_valid = v_q[LAST];
    assign result    = s_q[LAST];
    assign cout      = c_q[LAST];
    assign neg       = s_q[LAST][WIDTH-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign tag_out   = t_q[LAST];
endmodule

// File: tb/tb_csa_addsub_pipe.sv
// Bench for csa_addsub_pipe: directed cases, backpressure, reset flush and a
// randomized stream scored against an arithmetic reference model.
module tb_csa_addsub_pipe;
    localparam int WIDTH = 32, SEG = 4, STAGES = 2, TAG_W = 4;
    localparam int EW = TAG_W + 4 + WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             sub = 1'b0, use_cin = 1'b0, cin = 1'b0;
    logic [TAG_W-1:0] tag_in = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] result;
    logic             cout, ovf, zero, neg;
    logic [TAG_W-1:0] tag_out;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [EW-1:0] exp_q[$];

    csa_addsub_pipe #(.WIDTH(WIDTH), .SEG(SEG), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .use_cin(use_cin), .cin(cin), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .cout(cout), .ovf(ovf), .zero(zero), .neg(neg), .tag_out(tag_out)
    );

    // Clock and watchdog
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic; packs {tag, cout, ovf, zero, neg, result}
    function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                            input logic ms, input logic mu, input logic mc,
                                            input logic [TAG_W-1:0] mt);
        logic [WIDTH-1:0] bb;
        logic             c0;
        logic [WIDTH:0]   full;
        longint           st;
        logic             ov;
        bb   = ms ? ~mb : mb;
        c0   = mu ? mc : ms;
        full = {1'b0, ma} + {1'b0, bb} + (WIDTH+1)'(c0);
        st   = longint'($signed(ma)) + longint'($signed(bb)) + longint'(c0);
        ov   = (st > 64'sd2147483647) || (st < -64'sd2147483648);
        return {mt, full[WIDTH], ov, full[WIDTH-1:0] == '0, full[WIDTH-1], full[WIDTH-1:0]};
    endfunction

    // Scoreboard: sampled on the falling edge, mirrors the transfers of the next rising edge
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", out_valid, 1'b0);
                end else begin
                    check("out_fields", {tag_out, cout, ovf, zero, neg, result}, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(a, b, sub, use_cin, cin, tag_in));
        end
    end

    // Driver: offer one op and hold it until accepted
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic ts, input logic tu, input logic tc, input logic [TAG_W-1:0] tt);
        int n = 0;
        a = ta; b = tb; sub = ts; use_cin = tu; cin = tc; tag_in = tt;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_accept", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(7))
            0: return 32'hFFFF_FFFF;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int p0;
        int sent;
        logic [WIDTH-1:0] ra, rb;

        // Model pinned by hand-computed values
        check("model_wrap",  model(32'hFFFF_FFFF, 32'h1, 0, 0, 0, 4'd3), {4'd3, 4'b1010, 32'h0000_0000});
        check("model_ovf",   model(32'h7FFF_FFFF, 32'h1, 0, 0, 0, 4'd0), {4'd0, 4'b0101, 32'h8000_0000});
        check("model_subov", model(32'h8000_0000, 32'h1, 1, 0, 0, 4'd1), {4'd1, 4'b1100, 32'h7FFF_FFFF});
        check("model_neg",   model(32'd5, 32'd7, 1, 0, 0, 4'd2),         {4'd2, 4'b0001, 32'hFFFF_FFFE});
        check("model_cin",   model(32'h0000_FFFF, 32'h0, 0, 1, 1, 4'd4), {4'd4, 4'b0000, 32'h0001_0000});
        check("model_borrow",model(32'd10, 32'd3, 1, 1, 0, 4'd5),        {4'd5, 4'b1000, 32'h0000_0006});

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_fields", {tag_out, cout, ovf, zero, neg, result}, '0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Wrap-around add with latency check
        send(32'hFFFF_FFFF, 32'h1, 0, 0, 0, 4'd3);
        check("lat_not_yet", out_valid, 0);
        @(posedge clk); #1;
        check("lat_out_valid", out_valid, 1);
        check("t1_direct", {tag_out, cout, zero, ovf, neg, result}, {4'd3, 4'b1100, 32'h0});
        drain("t1_drain");

        // Flag cases and carry across the stage boundary, back-to-back
        send(32'h7FFF_FFFF, 32'h1, 0, 0, 0, 4'd1);
        send(32'h8000_0000, 32'h1, 1, 0, 0, 4'd2);
        send(32'd5, 32'd7, 1, 0, 0, 4'd3);
        send(32'h0000_FFFF, 32'h0, 0, 1, 1, 4'd4);
        send(32'd10, 32'd3, 1, 1, 0, 4'd5);
        drain("t23_drain");

        // Backpressure: out_ready low for cycles 3..7 while streaming tags 0..7
        p0 = pops;
        fork
            begin
                for (int t = 0; t < 8; t++)
                    send($urandom, $urandom, 1'($urandom_range(1)), 0, 0, 4'(t));
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    out_ready = !(c >= 3 && c <= 7);
                    @(negedge clk);
                    if (c == 5) check("stall_in_ready", in_ready, 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain("t4_drain");
        check("t4_count", pops - p0, 8);

        // Random stream with random valid/ready
        p0 = pops;
        sent = 0;
        while (sent < 10000) begin
            if (!in_valid && $urandom_range(3) != 0) begin
                ra = pick();
                rb = ($urandom_range(7) == 0) ? ra : pick();
                a = ra; b = rb;
                sub = 1'($urandom_range(1));
                use_cin = 1'($urandom_range(1));
                cin = 1'($urandom_range(1));
                tag_in = 4'($urandom_range(15));
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                @(posedge clk); #1;
                sent++;
                in_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        drain("t5_drain");
        check("t5_count", pops - p0, 10000);

        // Reset with two operations in flight
        out_ready = 1'b1;
        send(32'h1234_5678, 32'h1111_1111, 0, 0, 0, 4'd9);
        send(32'h0000_0001, 32'h0000_0002, 0, 0, 0, 4'd10);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t6_out_valid", out_valid, 0);
        check("t6_result", result, 0);
        check("t6_in_ready", in_ready, 1);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t6_no_stale", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
